// File: rtl/hpdcache_sram_ecc_rmw_1rw.sv
// 1RW SRAM wrapper with per-word Hsiao SECDED, hardware RMW for partial writes, scrub and error counter.
// Reads respond one cycle after acceptance; partial writes and scrubs hold req_ready_o low for one cycle.
module hpdcache_sram_wbyteenable_1rw #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 72,
  parameter int DEPTH     = 2**ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wbe,
  output logic [DATA_SIZE-1:0]   rdata
);
  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int b = 0; b < DATA_SIZE/8; b++) begin
          if (wbe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

module hpdcache_sram_ecc_rmw_1rw #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 2**ADDR_SIZE,
  parameter int NDATA     = 1,
  parameter int SCRUB_EN  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [ADDR_SIZE-1:0]            req_addr_i,
  input  logic [NDATA*DATA_SIZE-1:0]      req_wdata_i,
  input  logic [NDATA*DATA_SIZE/8-1:0]    req_wbe_i,
  input  logic                            err_inj_i,
  input  logic [NDATA*DATA_SIZE-1:0]      err_inj_msk_i,
  output logic                            rsp_valid_o,
  output logic [NDATA*DATA_SIZE-1:0]      rsp_rdata_o,
  output logic [NDATA-1:0]                rsp_err_cor_o,
  output logic [NDATA-1:0]                rsp_err_unc_o,
  output logic                            wr_err_unc_o,
  output logic [CNT_WIDTH-1:0]            cor_cnt_o,
  input  logic                            cor_cnt_clr_i
);
  function automatic int calc_r(input int k);
    int r;
    r = 2;
    while (((2 ** (r - 1)) - r) < k) r++;
    return r;
  endfunction

  localparam int R  = calc_r(DATA_SIZE);
  localparam int RP = ((R + 7) / 8) * 8;
  localparam int CW = DATA_SIZE + RP;
  localparam int NB = DATA_SIZE / 8;
  localparam int CB = CW / 8;

  if ((DATA_SIZE < 8) || ((DATA_SIZE % 8) != 0)) begin : g_bad_width
    $fatal(1, "DATA_SIZE must be a non-zero multiple of 8");
  end

  typedef logic [DATA_SIZE-1:0][R-1:0] hmat_t;

  // Hsiao columns: distinct odd-weight (>=3) vectors, lowest weight first
  function automatic hmat_t gen_h();
    hmat_t h;
    int    n;
    int    pc;
    h = '0;
    n = 0;
    for (int w = 3; w <= R; w += 2) begin
      for (int v = 0; v < 2 ** R; v++) begin
        pc = 0;
        for (int b = 0; b < R; b++) pc += (v >> b) & 1;
        if ((pc == w) && (n < DATA_SIZE)) begin
          h[n] = v[R-1:0];
          n++;
        end
      end
    end
    return h;
  endfunction

  localparam hmat_t H = gen_h();

  function automatic logic [R-1:0] syn_of(input logic [DATA_SIZE-1:0] d);
    logic [R-1:0] s;
    s = '0;
    for (int i = 0; i < DATA_SIZE; i++) if (d[i]) s ^= H[i];
    return s;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DATA_SIZE-1:0] d);
    logic [CW-1:0] cw;
    cw = '0;
    cw[DATA_SIZE-1:0]   = d;
    cw[DATA_SIZE +: R]  = syn_of(d);
    return cw;
  endfunction

  typedef enum logic [1:0] {IDLE, RD, RMW} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_SIZE-1:0]           addr_q, addr_d;
  logic [NDATA*DATA_SIZE-1:0]     wdata_q, wdata_d;
  logic [NDATA*NB-1:0]            wbe_q, wbe_d;
  logic                           inj_q, inj_d;
  logic [NDATA*DATA_SIZE-1:0]     inj_msk_q, inj_msk_d;
  logic [CNT_WIDTH-1:0]           cor_cnt_q, cor_cnt_d;

  logic                           sram_cs, sram_we;
  logic [ADDR_SIZE-1:0]           sram_addr;
  logic [NDATA*CW-1:0]            sram_wdata, sram_rdata;
  logic [NDATA*CB-1:0]            sram_wbe;

  logic [NDATA*DATA_SIZE-1:0]     dec_data;
  logic [NDATA-1:0]               dec_cor, dec_unc;

  always_comb begin : p_dec
    logic [DATA_SIZE-1:0] d;
    logic [R-1:0]         syn;
    dec_data = '0;
    dec_cor  = '0;
    dec_unc  = '0;
    for (int w = 0; w < NDATA; w++) begin
      d   = sram_rdata[w*CW +: DATA_SIZE];
      syn = syn_of(d) ^ sram_rdata[w*CW + DATA_SIZE +: R];
      if (syn != '0) begin
        if (^syn) begin
          // odd syndrome: single data bit, single check bit, or an aliasing triple error
          dec_unc[w] = ~$onehot(syn);
          for (int i = 0; i < DATA_SIZE; i++) begin
            if (H[i] == syn) begin
              d[i]       = ~d[i];
              dec_unc[w] = 1'b0;
            end
          end
          dec_cor[w] = ~dec_unc[w];
        end else begin
          dec_unc[w] = 1'b1;
        end
      end
      dec_data[w*DATA_SIZE +: DATA_SIZE] = d;
    end
  end

  logic                   acc, scrub, rmw_unc, req_partial;
  logic [NDATA*CW-1:0]    enc_req, enc_rmw, enc_scrub;
  logic [NDATA*CB-1:0]    req_wbe_cw, rmw_wbe_cw;

  always_comb begin : p_ctrl
    logic [NB-1:0]        wb;
    logic [DATA_SIZE-1:0] merged;
    logic [CW-1:0]        cw;
    req_partial = 1'b0;
    rmw_unc     = 1'b0;
    enc_req     = '0;
    enc_rmw     = '0;
    enc_scrub   = '0;
    req_wbe_cw  = '0;
    rmw_wbe_cw  = '0;
    for (int w = 0; w < NDATA; w++) begin
      wb = req_wbe_i[w*NB +: NB];
      if ((|wb) && !(&wb)) req_partial = 1'b1;
      cw = encode(req_wdata_i[w*DATA_SIZE +: DATA_SIZE]);
      if (err_inj_i) cw[DATA_SIZE-1:0] = cw[DATA_SIZE-1:0] ^ err_inj_msk_i[w*DATA_SIZE +: DATA_SIZE];
      enc_req[w*CW +: CW]    = cw;
      req_wbe_cw[w*CB +: CB] = {CB{&wb}};

      wb = wbe_q[w*NB +: NB];
      merged = dec_data[w*DATA_SIZE +: DATA_SIZE];
      for (int b = 0; b < NB; b++) begin
        if (wb[b]) merged[b*8 +: 8] = wdata_q[w*DATA_SIZE + b*8 +: 8];
      end
      cw = encode(merged);
      if (inj_q) cw[DATA_SIZE-1:0] = cw[DATA_SIZE-1:0] ^ inj_msk_q[w*DATA_SIZE +: DATA_SIZE];
      enc_rmw[w*CW +: CW]    = cw;
      rmw_wbe_cw[w*CB +: CB] = {CB{|wb}};
      rmw_unc = rmw_unc | ((|wb) & dec_unc[w]);

      enc_scrub[w*CW +: CW] = encode(dec_data[w*DATA_SIZE +: DATA_SIZE]);
    end

    scrub       = (SCRUB_EN != 0) && (state_q == RD) && (|dec_cor) && !(|dec_unc);
    req_ready_o = (state_q != RMW) && !scrub;
    acc         = req_valid_i & req_ready_o;

    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = req_addr_i;
    sram_wdata = enc_req;
    sram_wbe   = req_wbe_cw;
    if (state_q == RMW) begin
      sram_cs    = ~rmw_unc;
      sram_we    = 1'b1;
      sram_addr  = addr_q;
      sram_wdata = enc_rmw;
      sram_wbe   = rmw_wbe_cw;
    end else if (scrub) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = addr_q;
      sram_wdata = enc_scrub;
      sram_wbe   = '1;
    end else if (acc) begin
      sram_cs = 1'b1;
      sram_we = req_we_i & ~req_partial;
    end

    state_d   = IDLE;
    if ((state_q != RMW) && acc) begin
      if (!req_we_i)        state_d = RD;
      else if (req_partial) state_d = RMW;
    end
    addr_d    = acc ? req_addr_i    : addr_q;
    wdata_d   = acc ? req_wdata_i   : wdata_q;
    wbe_d     = acc ? req_wbe_i     : wbe_q;
    inj_d     = acc ? err_inj_i     : inj_q;
    inj_msk_d = acc ? err_inj_msk_i : inj_msk_q;

    cor_cnt_d = cor_cnt_q;
    if (cor_cnt_clr_i) begin
      cor_cnt_d = '0;
    end else if (((state_q == RD) || (state_q == RMW)) && (|dec_cor) && (cor_cnt_q != {CNT_WIDTH{1'b1}})) begin
      cor_cnt_d = cor_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      inj_q     <= 1'b0;
      inj_msk_q <= '0;
      cor_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      inj_q     <= inj_d;
      inj_msk_q <= inj_msk_d;
      cor_cnt_q <= cor_cnt_d;
    end
  end

  assign rsp_valid_o   = (state_q == RD);
  assign rsp_rdata_o   = dec_data;
  assign rsp_err_cor_o = dec_cor;
  assign rsp_err_unc_o = dec_unc;
  assign wr_err_unc_o  = (state_q == RMW) & rmw_unc;
  assign cor_cnt_o     = cor_cnt_q;

  hpdcache_sram_wbyteenable_1rw #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (NDATA*CW),
    .DEPTH     (DEPTH)
  ) i_sram (
    .clk   (clk),
    .cs    (sram_cs),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .wbe   (sram_wbe),
    .rdata (sram_rdata)
  );
endmodule

// File: tb/tb_hpdcache_sram_ecc_rmw_1rw.sv
// Directed bench for hpdcache_sram_ecc_rmw_1rw with a 2-bit error counter.
module tb_hpdcache_sram_ecc_rmw_1rw;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [5:0]  req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_wbe_i = '0;
  logic        err_inj_i = 1'b0;
  logic [63:0] err_inj_msk_i = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic [0:0]  rsp_err_cor_o;
  logic [0:0]  rsp_err_unc_o;
  logic        wr_err_unc_o;
  logic [1:0]  cor_cnt_o;
  logic        cor_cnt_clr_i = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hpdcache_sram_ecc_rmw_1rw #(
    .ADDR_SIZE (6),
    .DATA_SIZE (64),
    .NDATA     (1),
    .SCRUB_EN  (1),
    .CNT_WIDTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_wbe_i     (req_wbe_i),
    .err_inj_i     (err_inj_i),
    .err_inj_msk_i (err_inj_msk_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_cor_o (rsp_err_cor_o),
    .rsp_err_unc_o (rsp_err_unc_o),
    .wr_err_unc_o  (wr_err_unc_o),
    .cor_cnt_o     (cor_cnt_o),
    .cor_cnt_clr_i (cor_cnt_clr_i)
  );

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic [63:0] msk;
    logic [63:0] exp_data;
    logic        chk_data;
    logic        exp_cor;
    logic        exp_unc;
    logic        exp_rvld;
    logic        exp_rdy;
    logic        exp_wunc;
    logic [1:0]  exp_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // drive one request after the falling edge; returns #1 after the accepting edge (cycle T+1)
  task automatic send(input logic we, input logic [5:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [63:0] m);
    @(negedge clk);
    req_valid_i   = 1'b1;
    req_we_i      = we;
    req_addr_i    = a;
    req_wdata_i   = d;
    req_wbe_i     = be;
    err_inj_i     = (m != 64'h0);
    err_inj_msk_i = m;
    chk($sformatf("accept ready a=%0d", a), req_ready_o, 1'b1);
    @(posedge clk);
    #1;
    req_valid_i   = 1'b0;
    err_inj_i     = 1'b0;
    err_inj_msk_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          we    addr   wdata                   wbe    msk        exp_data               cd cor unc rv rdy wu cnt
    vecs[0]  = '{1'b1, 6'd3,  64'h0123456789ABCDEF, 8'hFF, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 6'd3,  64'h0,                8'h00, 64'h0,     64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 6'd5,  64'h1111111111111111, 8'hFF, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 6'd5,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 6'd5,  64'h0,                8'h00, 64'h0,     64'h11111111AAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 6'd7,  64'hDEADBEEFCAFEF00D, 8'hFF, 64'h1,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 6'd7,  64'h0,                8'h00, 64'h0,     64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 6'd7,  64'h0,                8'h00, 64'h0,     64'hDEADBEEFCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 6'd9,  64'h5555555555555555, 8'hFF, 64'h3,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 6'd9,  64'hFFFFFFFFFFFFFFFF, 8'h01, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 6'd9,  64'h0,                8'h00, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[11] = '{1'b1, 6'd11, 64'h2222222222222222, 8'hFF, 64'h100,   64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[12] = '{1'b1, 6'd11, 64'h3333333333333333, 8'h01, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[13] = '{1'b0, 6'd11, 64'h0,                8'h00, 64'h0,     64'h2222222222222233, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[14] = '{1'b1, 6'd12, 64'h0,                8'hFF, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[15] = '{1'b1, 6'd12, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'h1,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[16] = '{1'b0, 6'd12, 64'h0,                8'h00, 64'h0,     64'hFFFFFFFF00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
    vecs[17] = '{1'b0, 6'd12, 64'h0,                8'h00, 64'h0,     64'hFFFFFFFF00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[18] = '{1'b1, 6'd3,  64'h0,                8'h00, 64'h0,     64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    vecs[19] = '{1'b0, 6'd3,  64'h0,                8'h00, 64'h0,     64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", rsp_valid_o, 1'b0);
    chk("reset wr_err_unc", wr_err_unc_o, 1'b0);
    chk("reset cor_cnt", cor_cnt_o, 2'd0);
    chk("reset ready", req_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wbe, vecs[i].msk);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid_o, vecs[i].exp_rvld);
      chk($sformatf("v%0d ready t+1", i), req_ready_o, vecs[i].exp_rdy);
      chk($sformatf("v%0d wr_err_unc", i), wr_err_unc_o, vecs[i].exp_wunc);
      if (!vecs[i].we) begin
        chk($sformatf("v%0d err_cor", i), rsp_err_cor_o, vecs[i].exp_cor);
        chk($sformatf("v%0d err_unc", i), rsp_err_unc_o, vecs[i].exp_unc);
      end
      if (vecs[i].chk_data) chk($sformatf("v%0d rdata", i), rsp_rdata_o, vecs[i].exp_data);
      step();
      chk($sformatf("v%0d cor_cnt", i), cor_cnt_o, vecs[i].exp_cnt);
      chk($sformatf("v%0d ready t+2", i), req_ready_o, 1'b1);
      chk($sformatf("v%0d wr_err_unc t+2", i), wr_err_unc_o, 1'b0);
    end

    // counter saturation, then clear concurrent with a correctable read
    send(1'b1, 6'd13, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h80);
    step();
    send(1'b0, 6'd13, 64'h0, 8'h00, 64'h0);
    chk("sat err_cor", rsp_err_cor_o, 1'b1);
    chk("sat rdata", rsp_rdata_o, 64'hAAAAAAAAAAAAAAAA);
    step();
    chk("sat cor_cnt", cor_cnt_o, 2'd3);
    send(1'b1, 6'd13, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h1);
    step();
    send(1'b0, 6'd13, 64'h0, 8'h00, 64'h0);
    cor_cnt_clr_i = 1'b1;
    chk("clr err_cor", rsp_err_cor_o, 1'b1);
    step();
    cor_cnt_clr_i = 1'b0;
    chk("clr cor_cnt", cor_cnt_o, 2'd0);

    // request held valid behind a partial write: accepted only at T+2
    send(1'b1, 6'd20, 64'h1111111111111111, 8'hFF, 64'h0);
    step();
    send(1'b1, 6'd20, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    chk("b2b ready t+1", req_ready_o, 1'b0);
    step();
    chk("b2b ready t+2", req_ready_o, 1'b1);
    chk("b2b rsp_valid t+2", rsp_valid_o, 1'b0);
    step();
    req_valid_i = 1'b0;
    chk("b2b rsp_valid t+3", rsp_valid_o, 1'b1);
    chk("b2b rdata", rsp_rdata_o, 64'h11111111AAAAAAAA);
    step();

    // reset during the RMW write cycle drops the write
    send(1'b1, 6'd22, 64'h7777777777777777, 8'hFF, 64'h1);
    step();
    send(1'b0, 6'd22, 64'h0, 8'h00, 64'h0);
    step();
    chk("pre-reset cor_cnt", cor_cnt_o, 2'd1);
    send(1'b1, 6'd21, 64'h1111111111111111, 8'hFF, 64'h0);
    step();
    send(1'b1, 6'd21, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid-rmw reset rsp_valid", rsp_valid_o, 1'b0);
    chk("mid-rmw reset ready", req_ready_o, 1'b1);
    chk("mid-rmw reset cor_cnt", cor_cnt_o, 2'd0);
    chk("mid-rmw reset wr_err_unc", wr_err_unc_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 6'd21, 64'h0, 8'h00, 64'h0);
    chk("post-reset rsp_valid", rsp_valid_o, 1'b1);
    chk("post-reset rdata", rsp_rdata_o, 64'h1111111111111111);
    chk("post-reset err_cor", rsp_err_cor_o, 1'b0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
